// File: rtl/struct_param_regfile.sv
// struct_param_regfile: DEPTH-entry register file of packed {a,b,c,d} records.
// Every entry powers up to RESET_VAL. Writes are per-field masked, reads are
// registered with one cycle of latency, and a sequenced "restore defaults"
// operation rewrites one entry per cycle while blocking new writes.
module struct_param_regfile #(
    parameter int FIELD_W = 1,
    parameter int DEPTH   = 4,
    parameter logic [4*FIELD_W-1:0] RESET_VAL =
        {FIELD_W'(1), FIELD_W'(0), FIELD_W'(1), FIELD_W'(0)},
    localparam int RW = 4 * FIELD_W,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_field_en,
    input  logic [RW-1:0] wr_data,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [RW-1:0] rd_data,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done
);

    typedef struct packed {
        logic [FIELD_W-1:0] a;
        logic [FIELD_W-1:0] b;
        logic [FIELD_W-1:0] c;
        logic [FIELD_W-1:0] d;
    } rec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;
    rec_t          mem [DEPTH];
    rec_t          wr_rec;
    rec_t          rst_rec;
    rec_t          rd_rec;
    logic          wr_fire;

    assign wr_rec   = rec_t'(wr_data);
    assign rst_rec  = rec_t'(RESET_VAL);
    assign wr_ready = (state_q != CLEAR);
    assign wr_fire  = wr_valid && wr_ready;

    // Restore-defaults sequencer: state and clear-index register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and status decode for the restore-defaults sequencer.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                clr_done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Entry storage: reset, sequenced clear, or masked field write.
    // NOTE: the array is flop-based and reset on purpose; every entry must
    // read back RESET_VAL right after reset, so it cannot map to a RAM macro.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                mem[i] <= rst_rec;
            end else if (clr_busy && (cnt_q == AW'(i))) begin
                mem[i] <= rst_rec;
            end else if (wr_fire && (wr_addr == AW'(i))) begin
                // Out-of-range addresses match no entry, so they are dropped.
                if (wr_field_en[3]) mem[i].a <= wr_rec.a;
                if (wr_field_en[2]) mem[i].b <= wr_rec.b;
                if (wr_field_en[1]) mem[i].c <= wr_rec.c;
                if (wr_field_en[0]) mem[i].d <= wr_rec.d;
            end
        end
    end

    // Read mux: out-of-range addresses fall through to all-zero.
    always_comb begin
        rd_rec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) rd_rec = mem[i];
        end
    end

    // Registered read port; data holds when no new request arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) rd_data <= rd_rec;
        end
    end

endmodule

// File: doc/struct_param_regfile.md
Name: struct_param_regfile

Overview:
- Parametrised register file of DEPTH entries. Each entry is a packed record of four fields a, b, c, d, each FIELD_W bits wide; a occupies the MSBs and d the LSBs.
- Every entry's reset/default value is the packed-record parameter RESET_VAL.
- Supports per-field masked writes, registered reads, and a sequenced "restore defaults" operation.
- Serves as the configuration/status store for blocks that consume packed-struct parameters as power-on defaults.

Parameters:
- FIELD_W, 1, width of each of the four fields; record width RW = 4*FIELD_W.
- DEPTH, 4, number of entries; must be >= 1; need not be a power of two.
- RESET_VAL, field pattern {a:1, b:0, c:1, d:0} (4'b1010 at FIELD_W=1), RW-bit default record; each field value is zero-extended to FIELD_W.
- Derived AW = max(1, $clog2(DEPTH)); not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  AW  write entry index.
- wr_field_en  in  4  per-field write enable; bit3=a, bit2=b, bit1=c, bit0=d.
- wr_data  in  RW  write record.
- rd_req  in  1  read request; always accepted.
- rd_addr  in  AW  read entry index.
- rd_valid  out  1  rd_data valid this cycle.
- rd_data  out  RW  read record.
- clr_start  in  1  start restore-defaults sequence.
- clr_busy  out  1  sequence in progress.
- clr_done  out  1  one-cycle pulse when sequence completes.

Behaviour:
- Reset (rst=1 at a clock edge):
  - all DEPTH entries load RESET_VAL in that single cycle;
  - FSM goes to IDLE; clear counter goes to 0;
  - rd_valid=0, rd_data=0, clr_busy=0, clr_done=0.
  - wr_ready is combinational from state, so it reads 1 after reset.
  - Reset mid-sequence aborts it with no clr_done pulse.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when clr_start=1; clr_start in CLEAR or DONE is ignored.
  - CLEAR: writes RESET_VAL to entry cnt each cycle, cnt = 0..DEPTH-1 in order. After the write of DEPTH-1 -> DONE.
  - DONE: clr_done=1 for exactly one cycle, then -> IDLE.
  - clr_busy=1 exactly while in CLEAR.
  - Total sequence: DEPTH cycles in CLEAR plus 1 cycle in DONE.
- Writes:
  - wr_ready=1 in IDLE and DONE, 0 in CLEAR. Stalled requests are not queued; the requester holds wr_valid.
  - On an accepted write, each field whose wr_field_en bit is 1 takes the matching slice of wr_data; the other fields keep their value.
  - wr_field_en=0 on an accepted write is legal and is a no-op.
  - wr_addr >= DEPTH: the handshake completes and the array is unchanged.
  - Write accepted and clr_start in the same IDLE cycle: the write lands that cycle, CLEAR starts next cycle and overwrites it with RESET_VAL.
- Reads:
  - 1-cycle latency: rd_req at edge N gives rd_valid=1 and rd_data in cycle N+1.
  - Without a new rd_req, rd_valid returns to 0 and rd_data holds its last value.
  - Array is sampled before same-edge updates, so read-during-write to the same address returns the old record; the same applies to entries being cleared.
  - Reads are permitted in every state.
  - rd_addr >= DEPTH returns all-zero data with rd_valid=1.
- No X propagation: every entry is defined from reset onward.

Test Plan:
- Reset then read all entries, FIELD_W=1, DEPTH=4 -> every rd_data=4'b1010, rd_valid exactly one cycle after each rd_req.
- Write addr 2, wr_data=4'b0101, wr_field_en=4'b1100, then read addr 2 -> 4'b0110 (a, b replaced; c, d kept from default).
- Read and write addr 1 in the same cycle with data 4'b1111, en=4'b1111 -> first read returns 4'b1010; a read the next cycle returns 4'b1111.
- Load all entries with 4'b0000, pulse clr_start, hold wr_valid -> clr_busy high 4 cycles, wr_ready low 4 cycles, clr_done single pulse on cycle 5, held write accepted on cycle 5, all untouched entries read 4'b1010.
- Assert rst on the 2nd CLEAR cycle -> FSM to IDLE, no clr_done pulse, all entries 4'b1010.
- FIELD_W=3, DEPTH=5, RESET_VAL=pattern {a:3'd5, b:3'd0, c:3'd7, d:3'd2} -> reads give 12'b101_000_111_010; write to addr 6 leaves the array unchanged; read of addr 7 returns 0 with rd_valid=1.
